// File: rtl/xor_absorb_pipe.sv
// xor_absorb_pipe: registered ASCON state-XOR stage (padded rate absorb, key XOR, domain separation).
// Optional macro XOR_ABSORB_DECRYPT_EN adds decrypt_i, which overwrites the data bytes of the rate instead of XORing them.
module xor_absorb_pipe #(
    parameter int  RATE_W = 64,
    parameter int  CNT_W  = 16,
    localparam int LEN_W  = $clog2(RATE_W / 8) + 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [4:0][63:0]  state_i,
    input  logic [RATE_W-1:0] data_i,
    input  logic [LEN_W-1:0]  data_len_i,
    input  logic [127:0]      key_i,
    input  logic [2:0]        mode_i,
    input  logic              last_i,
`ifdef XOR_ABSORB_DECRYPT_EN
    input  logic              decrypt_i,
`endif
    output logic              valid_o,
    input  logic              ready_i,
    output logic [4:0][63:0]  state_o,
    output logic [RATE_W-1:0] cipher_o,
    output logic [CNT_W-1:0]  blk_cnt_o
);
    localparam int NB = RATE_W / 8;
    localparam int NW = RATE_W / 64;

    localparam logic [2:0] M_ABSORB = 3'd1;
    localparam logic [2:0] M_KFIN   = 3'd2;
    localparam logic [2:0] M_KTAIL  = 3'd3;
    localparam logic [2:0] M_DOMSEP = 3'd4;

    logic                 accept;
    logic [LEN_W-1:0]     len_clamped;
    logic [RATE_W-1:0]    pad_block;
    logic [RATE_W-1:0]    byte_mask;
    logic [RATE_W-1:0]    rate_in;
    logic [RATE_W-1:0]    rate_xor;
    logic [RATE_W-1:0]    rate_new;
    logic [RATE_W-1:0]    cipher_next;
    logic [4:0][63:0]     state_next;
    logic                 is_absorb;
    logic                 cnt_inc;
    logic [CNT_W-1:0]     cnt_base;
    logic [CNT_W-1:0]     cnt_next;

    logic                 valid_reg;
    logic                 last_reg;
    logic [4:0][63:0]     state_reg;
    logic [RATE_W-1:0]    cipher_reg;
    logic [CNT_W-1:0]     cnt_reg;

    assign ready_o     = !valid_reg || ready_i;
    assign accept      = valid_i && ready_o;
    assign len_clamped = (data_len_i > LEN_W'(NB)) ? LEN_W'(NB) : data_len_i;

    // Byte lanes: byte 0 is the most significant byte of the rate, as on data_i.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            localparam int HI = RATE_W - 1 - 8 * gi;
            logic in_data;
            assign in_data            = LEN_W'(gi) < len_clamped;
            assign pad_block[HI -: 8] = in_data ? data_i[HI -: 8]
                                      : (LEN_W'(gi) == len_clamped) ? 8'h80 : 8'h00;
            assign byte_mask[HI -: 8] = {8{in_data}};
        end
        for (genvar gi = 0; gi < NW; gi++) begin : g_word
            assign rate_in[RATE_W-1-64*gi -: 64] = state_i[gi];
        end
    endgenerate

    assign rate_xor = rate_in ^ pad_block;

`ifdef XOR_ABSORB_DECRYPT_EN
    // Padding byte and tail stay XORed; only the data bytes take the ciphertext directly.
    assign rate_new = decrypt_i ? ((rate_xor & ~byte_mask) | (data_i & byte_mask)) : rate_xor;
`else
    assign rate_new = rate_xor;
`endif

    assign is_absorb   = (mode_i == M_ABSORB) || (mode_i == M_KFIN);
    assign cipher_next = is_absorb ? (rate_xor & byte_mask) : '0;
    assign cnt_inc     = (mode_i >= M_ABSORB) && (mode_i <= M_DOMSEP);

    always_comb begin
        state_next = state_i;
        if (is_absorb) begin
            for (int i = 0; i < NW; i++) begin
                state_next[i] = rate_new[RATE_W-1-64*i -: 64];
            end
        end
        case (mode_i)
            M_KFIN: begin
                state_next[NW]   = state_next[NW]   ^ key_i[127:64];
                state_next[NW+1] = state_next[NW+1] ^ key_i[63:0];
            end
            M_KTAIL: begin
                state_next[3] = state_next[3] ^ key_i[127:64];
                state_next[4] = state_next[4] ^ key_i[63:0];
            end
            M_DOMSEP: state_next[4] = state_next[4] ^ 64'h1;
            default: ;
        endcase
    end

    // A run closed by last_i restarts from zero on the cycle after its final transfer.
    assign cnt_base = last_reg ? '0 : cnt_reg;
    assign cnt_next = (cnt_inc && (cnt_base != {CNT_W{1'b1}})) ? cnt_base + CNT_W'(1) : cnt_base;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_reg  <= 1'b0;
            last_reg   <= 1'b0;
            state_reg  <= '0;
            cipher_reg <= '0;
            cnt_reg    <= '0;
        end else if (accept) begin
            valid_reg  <= 1'b1;
            last_reg   <= last_i;
            state_reg  <= state_next;
            cipher_reg <= cipher_next;
            cnt_reg    <= cnt_next;
        end else begin
            if (ready_i) begin
                valid_reg <= 1'b0;
            end
            last_reg <= 1'b0;
            cnt_reg  <= cnt_base;
        end
    end

    assign valid_o   = valid_reg;
    assign state_o   = state_reg;
    assign cipher_o  = cipher_reg;
    assign blk_cnt_o = cnt_reg;
endmodule
